ctrl_decode_seq: RTL

Parametrised, sequenced successor to the processor's combinational instruction decoder. Owns the fetch/execute phase internally instead of taking it as an input. Maps {opcode, flags} to a registered control word through a run-time programmable decode table. Adds stall, halt and resume. Sits between the instruction register / flag register and the datapath control lines.

---
 rtl/ctrl_decode_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ctrl_decode_seq.sv
// Sequenced instruction decoder: owns the fetch/execute phase and maps
// {opcode, flags} through a run-time programmable table to a registered control word.
module ctrl_decode_seq #(
  parameter int              OPW        = 4,
  parameter int              FW         = 2,
  parameter int              CW         = 13,
  parameter logic [CW-1:0]   FETCH_WORD = 13'h1001,
  parameter bit              HALT_EN    = 1'b1,
  parameter logic [OPW-1:0]  HALT_OP    = 4'b1111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    instr,
  input  logic [FW-1:0]     flags,
  input  logic              stall,
  input  logic              resume,
  input  logic              cfg_we,
  input  logic [OPW+FW-1:0] cfg_addr,
  input  logic [CW-1:0]     cfg_data,
  output logic [CW-1:0]     ctrl,
  output logic              phase,
  output logic              halted
);

  localparam int AW    = OPW + FW;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state_p0;
  state_t          state_nxt;
  logic [CW-1:0]   ctrl_nxt;
  logic            phase_nxt;
  logic            halted_nxt;
  logic            halt_pend_p0;
  logic            halt_pend_nxt;

  logic [CW-1:0]   table_q [DEPTH];
  logic [AW-1:0]   rd_addr;
  logic [CW-1:0]   rd_data;

  function automatic logic is_halt_op(input logic [OPW-1:0] op);
    return HALT_EN && (op == HALT_OP);
  endfunction

  assign rd_addr = {instr, flags};
  assign rd_data = table_q[rd_addr];

  // Decode table: cleared by reset, written independently of stall.
  // The lookup above sees the pre-edge contents, giving read-before-write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else if (cfg_we) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  // Next-state and next-output selection; stall freezes everything.
  always_comb begin
    state_nxt     = state_p0;
    ctrl_nxt      = ctrl;
    phase_nxt     = phase;
    halted_nxt    = halted;
    halt_pend_nxt = halt_pend_p0;
    if (!stall) begin
      unique case (state_p0)
        S_RST: begin
          state_nxt = S_FETCH;
          ctrl_nxt  = FETCH_WORD;
          phase_nxt = 1'b0;
        end
        S_FETCH: begin
          state_nxt     = S_EXEC;
          ctrl_nxt      = rd_data;
          phase_nxt     = 1'b1;
          halt_pend_nxt = is_halt_op(instr);
        end
        S_EXEC: begin
          phase_nxt = 1'b0;
          if (halt_pend_p0) begin
            state_nxt  = S_HALT;
            ctrl_nxt   = '0;
            halted_nxt = 1'b1;
          end else begin
            state_nxt = S_FETCH;
            ctrl_nxt  = FETCH_WORD;
          end
        end
        S_HALT: begin
          if (resume) begin
            state_nxt  = S_FETCH;
            ctrl_nxt   = FETCH_WORD;
            halted_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt = S_RST;
        end
      endcase
    end
  end

  // Registered state and outputs: one-edge latency, glitch-free ctrl.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0     <= S_RST;
      ctrl         <= '0;
      phase        <= 1'b0;
      halted       <= 1'b0;
      halt_pend_p0 <= 1'b0;
    end else begin
      state_p0     <= state_nxt;
      ctrl         <= ctrl_nxt;
      phase        <= phase_nxt;
      halted       <= halted_nxt;
      halt_pend_p0 <= halt_pend_nxt;
    end
  end

endmodule
